systolic_feeder: RTL and testbench

//  Upstream feeder for the systolic PE array (one instance per array edge).

---
 rtl/systolic_pkg.sv | 17 +
 rtl/skew_delay_line.sv | 30 +++
 rtl/systolic_feeder.sv | 143 ++++++++++++++
 tb/tb_systolic_feeder.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared constants for the systolic array edge feeder.
// FSM encoding, default geometry and counter sizing helper.
package systolic_pkg;

  localparam int DATA_WIDTH_DEF = 4;
  localparam int ARRAY_DIM_DEF  = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_STREAM = 2'd2;
  localparam logic [1:0] S_DRAIN  = 2'd3;

  function automatic int cnt_width(input int dim);
    return $clog2(dim) + 1;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// Fixed-depth shift register carrying a {valid, data} pair.
// Depth 1 acts as a plain output register.
module skew_delay_line #(
  parameter int DATA_WIDTH = 4,
  parameter int DEPTH      = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH:0] sr_q [DEPTH];

  // shift one stage per cycle, unconditionally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) sr_q[k] <= '0;
    end else begin
      sr_q[0] <= {valid_i, data_i};
      for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
    end
  end

  assign valid_o = sr_q[DEPTH-1][DATA_WIDTH];
  assign data_o  = sr_q[DEPTH-1][DATA_WIDTH-1:0];

endmodule

// File: rtl/systolic_feeder.sv
// Edge feeder for the PE array: weight-row loader plus
// diagonally skewed activation streamer.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ARRAY_DIM  = ARRAY_DIM_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start_load,
  input  logic                            start_stream,
  input  logic                            w_valid,
  output logic                            w_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] w_row,
  input  logic                            a_valid,
  output logic                            a_ready,
  input  logic                            a_last,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] a_vec,
  output logic                            pe_load,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] pe_weight,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] pe_val,
  output logic [ARRAY_DIM-1:0]            pe_val_valid,
  output logic                            busy,
  output logic                            done
);

  localparam int DW    = DATA_WIDTH;
  localparam int VW    = ARRAY_DIM * DATA_WIDTH;
  localparam int CNT_W = cnt_width(ARRAY_DIM);
  localparam logic [CNT_W-1:0] LAST_CNT =
    CNT_W'(ARRAY_DIM - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic             done_q, done_d;
  logic             load_q, load_d;
  logic [VW-1:0]    weight_q, weight_d;
  logic             w_ready_q, a_ready_q, busy_q;
  logic             w_hs, a_hs;

  assign w_hs = w_valid & w_ready_q;
  assign a_hs = a_valid & a_ready_q;

  // next-state, counters and weight-path decisions
  always_comb begin
    state_d     = state_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    done_d      = 1'b0;
    load_d      = 1'b0;
    weight_d    = weight_q;
    case (state_q)
      S_IDLE: begin
        if (start_load) begin
          state_d   = S_LOAD;
          row_cnt_d = '0;
        end else if (start_stream) begin
          state_d = S_STREAM;
        end
      end
      S_LOAD: begin
        if (w_hs) begin
          load_d   = 1'b1;
          weight_d = w_row;
          if (row_cnt_q == LAST_CNT) begin
            state_d   = S_IDLE;
            done_d    = 1'b1;
            row_cnt_d = '0;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      S_STREAM: begin
        if (a_hs && a_last) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        // leave so done lands with the last row's element
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_cnt_d == LAST_CNT) begin
          state_d     = S_IDLE;
          done_d      = 1'b1;
          drain_cnt_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state, counters and registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      row_cnt_q   <= '0;
      drain_cnt_q <= '0;
      done_q      <= 1'b0;
      load_q      <= 1'b0;
      weight_q    <= '0;
      w_ready_q   <= 1'b0;
      a_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      done_q      <= done_d;
      load_q      <= load_d;
      weight_q    <= weight_d;
      w_ready_q   <= (state_d == S_LOAD);
      a_ready_q   <= (state_d == S_STREAM);
      busy_q      <= (state_d != S_IDLE);
    end
  end

  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_row
    logic [DW-1:0] din;
    assign din = a_hs ? a_vec[i*DW +: DW] : '0;
    skew_delay_line #(
      .DATA_WIDTH(DW),
      .DEPTH     (i + 1)
    ) u_skew (
      .clk    (clk),
      .reset  (reset),
      .valid_i(a_hs),
      .data_i (din),
      .valid_o(pe_val_valid[i]),
      .data_o (pe_val[i*DW +: DW])
    );
  end

  assign w_ready   = w_ready_q;
  assign a_ready   = a_ready_q;
  assign pe_load   = load_q;
  assign pe_weight = weight_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder (DW=4, DIM=4).
// Expected values are hand-derived cycle by cycle.
module tb_systolic_feeder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_load = 1'b0;
  logic        start_stream = 1'b0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [15:0] w_row = '0;
  logic        a_valid = 1'b0;
  logic        a_ready;
  logic        a_last = 1'b0;
  logic [15:0] a_vec = '0;
  logic        pe_load;
  logic [15:0] pe_weight;
  logic [15:0] pe_val;
  logic [3:0]  pe_val_valid;
  logic        busy;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  systolic_feeder #(.DATA_WIDTH(4), .ARRAY_DIM(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .start_load  (start_load),
    .start_stream(start_stream),
    .w_valid     (w_valid),
    .w_ready     (w_ready),
    .w_row       (w_row),
    .a_valid     (a_valid),
    .a_ready     (a_ready),
    .a_last      (a_last),
    .a_vec       (a_vec),
    .pe_load     (pe_load),
    .pe_weight   (pe_weight),
    .pe_val      (pe_val),
    .pe_val_valid(pe_val_valid),
    .busy        (busy),
    .done        (done)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic lcyc(input logic wv,
                      input logic [15:0] row,
                      input logic el,
                      input logic [15:0] ew,
                      input logic ed,
                      input logic eb);
    w_valid = wv;
    w_row   = row;
    cyc();
    check("pe_load", 32'(pe_load), 32'(el));
    check("pe_weight", 32'(pe_weight), 32'(ew));
    check("load_done", 32'(done), 32'(ed));
    check("load_busy", 32'(busy), 32'(eb));
    check("load_valid", 32'(pe_val_valid), 32'(0));
    check("load_aready", 32'(a_ready), 32'(0));
  endtask

  task automatic scyc(input logic av,
                      input logic al,
                      input logic [15:0] vec,
                      input logic [3:0] ev,
                      input logic [15:0] eval,
                      input logic ed,
                      input logic ear,
                      input logic eb);
    a_valid = av;
    a_last  = al;
    a_vec   = vec;
    cyc();
    check("val_valid", 32'(pe_val_valid), 32'(ev));
    check("pe_val", 32'(pe_val), 32'(eval));
    check("strm_done", 32'(done), 32'(ed));
    check("a_ready", 32'(a_ready), 32'(ear));
    check("strm_busy", 32'(busy), 32'(eb));
    check("strm_load", 32'(pe_load), 32'(0));
    check("strm_wready", 32'(w_ready), 32'(0));
  endtask

  initial begin
    // reset state
    cyc();
    cyc();
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_wready", 32'(w_ready), 32'(0));
    check("rst_aready", 32'(a_ready), 32'(0));
    check("rst_val", 32'(pe_val), 32'(0));
    check("rst_valid", 32'(pe_val_valid), 32'(0));
    reset = 1'b0;
    cyc();

    // both starts in IDLE: load wins, stream dropped
    start_load   = 1'b1;
    start_stream = 1'b1;
    cyc();
    start_load   = 1'b0;
    start_stream = 1'b0;
    check("both_wready", 32'(w_ready), 32'(1));
    check("both_aready", 32'(a_ready), 32'(0));
    check("both_busy", 32'(busy), 32'(1));
    lcyc(1'b1, 16'h4321, 1'b1, 16'h4321, 1'b0, 1'b1);
    start_stream = 1'b1;
    lcyc(1'b1, 16'h8765, 1'b1, 16'h8765, 1'b0, 1'b1);
    start_stream = 1'b0;
    lcyc(1'b1, 16'hCBA9, 1'b1, 16'hCBA9, 1'b0, 1'b1);
    lcyc(1'b1, 16'h0FED, 1'b1, 16'h0FED, 1'b1, 1'b0);
    lcyc(1'b0, 16'h0000, 1'b0, 16'h0FED, 1'b0, 1'b0);
    check("post_ld_aready", 32'(a_ready), 32'(0));
    check("post_ld_wready", 32'(w_ready), 32'(0));

    // load with a two-cycle w_valid gap after row 2
    start_load = 1'b1;
    cyc();
    start_load = 1'b0;
    check("ld2_wready", 32'(w_ready), 32'(1));
    lcyc(1'b1, 16'h1357, 1'b1, 16'h1357, 1'b0, 1'b1);
    lcyc(1'b1, 16'h2468, 1'b1, 16'h2468, 1'b0, 1'b1);
    lcyc(1'b0, 16'hDEAD, 1'b0, 16'h2468, 1'b0, 1'b1);
    lcyc(1'b0, 16'hBEEF, 1'b0, 16'h2468, 1'b0, 1'b1);
    lcyc(1'b1, 16'h9ACE, 1'b1, 16'h9ACE, 1'b0, 1'b1);
    lcyc(1'b1, 16'hF0E1, 1'b1, 16'hF0E1, 1'b1, 1'b0);
    lcyc(1'b0, 16'h0000, 1'b0, 16'hF0E1, 1'b0, 1'b0);

    // single vector, e0..e3 = 4,3,2,1, with a_last
    start_stream = 1'b1;
    cyc();
    start_stream = 1'b0;
    check("s1_aready", 32'(a_ready), 32'(1));
    scyc(1'b1, 1'b1, 16'h1234, 4'b0001, 16'h0004, 1'b0, 1'b0, 1'b1);
    scyc(1'b0, 1'b0, 16'h0000, 4'b0010, 16'h0030, 1'b0, 1'b0, 1'b1);
    scyc(1'b0, 1'b0, 16'h0000, 4'b0100, 16'h0200, 1'b0, 1'b0, 1'b1);
    scyc(1'b0, 1'b0, 16'h0000, 4'b1000, 16'h1000, 1'b1, 1'b0, 1'b0);
    scyc(1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // v0, bubble, v1 (signed -8/7) last; start_load while busy
    start_stream = 1'b1;
    cyc();
    start_stream = 1'b0;
    scyc(1'b1, 1'b0, 16'h4321, 4'b0001, 16'h0001, 1'b0, 1'b1, 1'b1);
    start_load = 1'b1;
    scyc(1'b0, 1'b0, 16'h0000, 4'b0010, 16'h0020, 1'b0, 1'b1, 1'b1);
    start_load = 1'b0;
    scyc(1'b1, 1'b1, 16'h7878, 4'b0101, 16'h0308, 1'b0, 1'b0, 1'b1);
    scyc(1'b0, 1'b0, 16'h0000, 4'b1010, 16'h4070, 1'b0, 1'b0, 1'b1);
    scyc(1'b0, 1'b0, 16'h0000, 4'b0100, 16'h0800, 1'b0, 1'b0, 1'b1);
    scyc(1'b0, 1'b0, 16'h0000, 4'b1000, 16'h7000, 1'b1, 1'b0, 1'b0);
    scyc(1'b0, 1'b0, 16'h0000, 4'b0000, 16'h0000, 1'b0, 1'b0, 1'b0);

    // reset mid-stream with two vectors in flight
    start_stream = 1'b1;
    cyc();
    start_stream = 1'b0;
    scyc(1'b1, 1'b0, 16'h4321, 4'b0001, 16'h0001, 1'b0, 1'b1, 1'b1);
    scyc(1'b1, 1'b0, 16'h8765, 4'b0011, 16'h0025, 1'b0, 1'b1, 1'b1);
    a_valid = 1'b0;
    reset   = 1'b1;
    cyc();
    check("mid_rst_valid", 32'(pe_val_valid), 32'(0));
    check("mid_rst_val", 32'(pe_val), 32'(0));
    check("mid_rst_busy", 32'(busy), 32'(0));
    check("mid_rst_done", 32'(done), 32'(0));
    check("mid_rst_weight", 32'(pe_weight), 32'(0));
    check("mid_rst_aready", 32'(a_ready), 32'(0));
    reset = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cyc();
      check("post_rst_done", 32'(done), 32'(0));
      check("post_rst_valid", 32'(pe_val_valid), 32'(0));
      check("post_rst_busy", 32'(busy), 32'(0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
